// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared CPU definitions for the multiply/divide unit
package mul_div_unit_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_DIVU  = 2'b01;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative unsigned 32x32 multiply / 32/32 divide into HI/LO
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_data,
  input  logic [31:0] tar_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  mdu_state_t  r_state;
  mdu_state_t  w_state_next;
  logic [1:0]  r_op;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_part;
  logic [32:0] w_div_diff;
  logic [63:0] w_step;

  always_comb begin
    w_accept     = start && !op[1] && (r_state != MDU_RUN);
    w_last       = (r_cnt == 5'(MDU_STEPS - 1));
    w_state_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_state_next = MDU_RUN;
      MDU_RUN:  if (w_last) w_state_next = MDU_DONE;
      MDU_DONE: w_state_next = w_accept ? MDU_RUN : MDU_IDLE;
      default:  w_state_next = MDU_IDLE;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_div_part = r_acc[63:31];
    w_div_diff = w_div_part - {1'b0, r_b};
    w_step     = {w_mul_sum, r_acc[31:1]};
    if (r_op == MDU_DIVU) begin
      if (w_div_diff[32])
        w_step = {w_div_part[31:0], r_acc[30:0], 1'b0};
      else
        w_step = {w_div_diff[31:0], r_acc[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_op    <= MDU_MULTU;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == MDU_RUN);
      r_done  <= (w_state_next == MDU_DONE);
      if (w_accept) begin
        r_op  <= op;
        r_cnt <= '0;
        r_acc <= {32'd0, (op == MDU_DIVU) ? src_data : tar_data};
        r_b   <= (op == MDU_DIVU) ? tar_data : src_data;
      end else if (r_state == MDU_RUN) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_hi <= w_step[63:32];
          r_lo <= w_step[31:0];
        end
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_data;
  logic [31:0] tar_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_data(src_data), .tar_data(tar_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == 2'b00) return 64'(a) * 64'(b);
    if (b == 0) return {a, 32'hFFFFFFFF};
    return {a % b, a / b};
  endfunction

  // Issues one request and waits for done; lat counts negedges after the accept-edge sample.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int bcyc, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; src_data = a; tar_data = b;
    @(negedge clk);
    start = 1'b0; src_data = $urandom; tar_data = $urandom; op = 2'(($urandom_range(0, 1)));
    bcyc = busy ? 1 : 0;
    lat  = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b00; src_data = 32'd3; tar_data = 32'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult_max();
    logic [31:0] rh, rl;
    int bc, lat;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, bc, lat);
    checks++;
    if (rh !== 32'hFFFFFFFE || rl !== 32'h00000001) begin
      errors++;
      $display("FAIL mult_max: hi=%h lo=%h, required fffffffe 00000001", rh, rl);
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL mult_latency: got %0d, required 32", lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || hi !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL done_pulse: done=%b hi=%h one cycle later, required 0 fffffffe", done, hi);
    end
  endtask

  task automatic test_div();
    logic [31:0] rh, rl;
    int bc, lat;
    run_op(2'b01, 32'd100, 32'd7, rh, rl, bc, lat);
    checks++;
    if (rh !== 32'd2 || rl !== 32'd14) begin
      errors++;
      $display("FAIL div_100_7: hi=%0d lo=%0d, required 2 14", rh, rl);
    end
    checks++;
    if (bc !== 32) begin
      errors++;
      $display("FAIL div_busy_cycles: got %0d, required 32", bc);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] rh, rl;
    int bc, lat;
    run_op(2'b01, 32'h00001234, 32'd0, rh, rl, bc, lat);
    checks++;
    if (rh !== 32'h00001234 || rl !== 32'hFFFFFFFF || lat !== 32) begin
      errors++;
      $display("FAIL div_zero: hi=%h lo=%h lat=%0d, required 00001234 ffffffff 32", rh, rl, lat);
    end
  endtask

  task automatic test_reserved_op();
    logic [31:0] hold_hi, hold_lo;
    int seen_busy = 0;
    hold_hi = hi; hold_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_data = 32'd5; tar_data = 32'd6;
    @(negedge clk);
    op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) seen_busy++;
    end
    checks++;
    if (seen_busy !== 0 || hi !== hold_hi || lo !== hold_lo) begin
      errors++;
      $display("FAIL reserved_op: activity=%0d hi=%h lo=%h, required 0 %h %h", seen_busy, hi, lo, hold_hi, hold_lo);
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_data = 32'd3; tar_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(negedge clk); lat++; end
    start = 1'b1; op = 2'b01; src_data = 32'd9; tar_data = 32'd2;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15 || lat !== 32) begin
      errors++;
      $display("FAIL ignore_start: hi=%0d lo=%0d lat=%0d, required 0 15 32", hi, lo, lat);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b after result, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl;
    int bc, lat;
    run_op(2'b00, 32'd3, 32'd5, rh, rl, bc, lat);
    checks++;
    if (rl !== 32'd15 || rh !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: hi=%0d lo=%0d, required 0 15", rh, rl);
    end
    start = 1'b1; op = 2'b01; src_data = 32'd9; tar_data = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b right after DONE-cycle start, required 1", busy);
    end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (hi !== 32'd1 || lo !== 32'd4 || lat !== 32) begin
      errors++;
      $display("FAIL b2b_second: hi=%0d lo=%0d lat=%0d, required 1 4 32", hi, lo, lat);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rh, rl;
    int bc, lat;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_data = 32'd7; tar_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_abort_done: %0d done pulses, required 0", dones);
    end
    run_op(2'b00, 32'd6, 32'd7, rh, rl, bc, lat);
    checks++;
    if (rl !== 32'd42 || rh !== 32'd0) begin
      errors++;
      $display("FAIL after_abort: hi=%0d lo=%0d, required 0 42", rh, rl);
    end
  endtask

  task automatic test_random();
    logic [31:0] rh, rl, a, b;
    logic [1:0]  o;
    logic [63:0] exp;
    int bc, lat;
    for (int i = 0; i < 24; i++) begin
      o = 2'(($urandom_range(0, 1)));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, rh, rl, bc, lat);
      checks++;
      if (rh !== exp[63:32] || rl !== exp[31:0] || lat !== 32 || bc !== 32) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d busy=%0d, required %h %h 32 32",
                 i, o, a, b, rh, rl, lat, bc, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_data = '0; tar_data = '0;
    test_reset();
    test_mult_max();
    test_div();
    test_div_zero();
    test_reserved_op();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
